// File: rtl/memory_handshake_ctrl.sv
// memory_handshake_ctrl
//   Byte-addressed RAM behind a MOV/MOC handshake. The control unit raises MOV with an address,
//   direction and access size; the block captures them, waits WAIT_CYCLES edges, performs a
//   big-endian byte/halfword/word access and answers with a registered MOC until MOV drops.
//   Misaligned accesses complete with align_err instead of touching the RAM.
// Ports
//   clk          rising-edge clock
//   clr          synchronous active-low reset (RAM contents are kept)
//   MOV          memory operation valid, held until MOC is seen
//   RW           1 = read, 0 = write
//   access_type  00 byte, 01 halfword, 10/11 word
//   address      byte address
//   data_in      right-justified write data
//   data_out     right-justified, zero-extended read data
//   MOC          operation complete
//   align_err    access aborted on misalignment, valid while MOC = 1
module memory_handshake_ctrl #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        access_type,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              MOC,
  output logic              align_err
);

  localparam int unsigned Depth    = 1 << ADDR_W;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Access parameters frozen at the capture edge.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [1:0]        type_q, type_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0] data_out_q, data_out_d;
  logic        moc_q, moc_d;
  logic        align_err_q, align_err_d;

  logic [7:0] mem_q [Depth];

  logic                   capture;
  logic                   complete;
  logic                   aligned;
  logic [3:0][ADDR_W-1:0] byte_addr;
  logic [3:0][7:0]        wbyte;
  logic [3:0]             we;
  logic [31:0]            rd_word;

  // State register
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      type_q      <= '0;
      wdata_q     <= '0;
      data_out_q  <= '0;
      moc_q       <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      type_q      <= type_d;
      wdata_q     <= wdata_d;
      data_out_q  <= data_out_d;
      moc_q       <= moc_d;
      align_err_q <= align_err_d;
    end
  end

  // Next-state logic. WAIT is entered even with WAIT_CYCLES = 0 so that MOC always rises
  // WAIT_CYCLES + 1 edges after the capture edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MOV) begin
          capture = 1'b1;
          cnt_d   = WaitInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (!MOV) begin
          // Control unit withdrew the request: abandon without touching the RAM.
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          complete = 1'b1;
          state_d  = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        if (!MOV) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values
  always_comb begin
    addr_d  = capture ? address     : addr_q;
    rw_d    = capture ? RW          : rw_q;
    type_d  = capture ? access_type : type_q;
    wdata_d = capture ? data_in     : wdata_q;

    unique case (type_q)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_q[0];
      default: aligned = (addr_q[1:0] == 2'b00);
    endcase

    // Plain width truncation gives the modulo-Depth wrap.
    for (int k = 0; k < 4; k++) begin
      byte_addr[k] = addr_q + ADDR_W'(k);
    end

    unique case (type_q)
      2'b00: begin
        we      = 4'b0001;
        wbyte   = {8'h00, 8'h00, 8'h00, wdata_q[7:0]};
        rd_word = {24'h0, mem_q[byte_addr[0]]};
      end
      2'b01: begin
        we      = 4'b0011;
        wbyte   = {8'h00, 8'h00, wdata_q[7:0], wdata_q[15:8]};
        rd_word = {16'h0, mem_q[byte_addr[0]], mem_q[byte_addr[1]]};
      end
      default: begin
        we      = 4'b1111;
        wbyte   = {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]};
        rd_word = {mem_q[byte_addr[0]], mem_q[byte_addr[1]],
                   mem_q[byte_addr[2]], mem_q[byte_addr[3]]};
      end
    endcase

    // A reset on the completing edge must not let the write through.
    if (!(complete && aligned && !rw_q && clr)) we = 4'b0000;

    data_out_d = (complete && aligned && rw_q) ? rd_word : data_out_q;

    if (complete) begin
      align_err_d = ~aligned;
    end else if (state_d == StIdle) begin
      align_err_d = 1'b0;
    end else begin
      align_err_d = align_err_q;
    end

    moc_d = (state_d == StAck);
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) mem_q[byte_addr[k]] <= wbyte[k];
    end
  end

  // Outputs come straight from registers; no path from MOV to MOC.
  always_comb begin
    data_out  = data_out_q;
    MOC       = moc_q;
    align_err = align_err_q;
  end

endmodule

// File: tb/tb_memory_handshake_ctrl.sv
module tb_memory_handshake_ctrl;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  // Index 0: WAIT_CYCLES = 2 instance, index 1: WAIT_CYCLES = 0 instance.
  logic        clr [2];
  logic        mov [2];
  logic        rw  [2];
  logic [1:0]  ty  [2];
  logic [8:0]  addr[2];
  logic [31:0] din [2];
  logic [31:0] dout[2];
  logic        moc [2];
  logic        aerr[2];

  logic [7:0]  model  [512];
  logic [31:0] last_rd[2];
  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  memory_handshake_ctrl #(.ADDR_W(9), .WAIT_CYCLES(2)) dut (
    .clk(clk), .clr(clr[0]), .MOV(mov[0]), .RW(rw[0]), .access_type(ty[0]),
    .address(addr[0]), .data_in(din[0]), .data_out(dout[0]), .MOC(moc[0]),
    .align_err(aerr[0])
  );

  memory_handshake_ctrl #(.ADDR_W(9), .WAIT_CYCLES(0)) dut_fast (
    .clk(clk), .clr(clr[1]), .MOV(mov[1]), .RW(rw[1]), .access_type(ty[1]),
    .address(addr[1]), .data_in(din[1]), .data_out(dout[1]), .MOC(moc[1]),
    .align_err(aerr[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full handshake on instance s; hold = extra cycles MOV stays high after MOC.
  task automatic mem_op(input int s, input logic r, input logic [1:0] t, input logic [8:0] a,
                        input logic [31:0] d, input int hold, input string tag);
    int          n;
    int          lat;
    int          w;
    logic        ok;
    logic        got;
    logic [8:0]  ak;
    logic [31:0] rd;
    exp_t        e;
    w  = (s == 0) ? 2 : 0;
    ok = (t == 2'b00) || (t == 2'b01 && !a[0]) || (t[1] && a[1:0] == 2'b00);
    n  = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
    rd = '0;
    for (int k = 0; k < n; k++) begin
      ak = a + 9'(k);
      if (!r && ok) model[ak] = 8'(d >> (8 * (n - 1 - k)));
      rd = (rd << 8) | {24'h0, model[ak]};
    end
    if (r && ok) last_rd[s] = rd;
    e.data = last_rd[s];
    e.err  = ~ok;
    sb.push_back(e);

    @(negedge clk);
    rw[s] = r; ty[s] = t; addr[s] = a; din[s] = d; mov[s] = 1'b1;
    @(posedge clk);
    #1;
    // Inputs scrambled after capture must not affect the access.
    rw[s] = ~r; ty[s] = ~t; addr[s] = ~a; din[s] = ~d;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      got = moc[s];
    end
    if (!got) check_eq({tag, "_moc_timeout"}, 32'd0, 32'd1);
    else      check_eq({tag, "_latency"}, 32'(lat), 32'(w + 1));
    e = sb.pop_front();
    check_eq({tag, "_data"}, dout[s], e.data);
    check_eq({tag, "_align_err"}, {31'h0, aerr[s]}, {31'h0, e.err});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_moc"}, {31'h0, moc[s]}, 32'd1);
      check_eq({tag, "_hold_data"}, dout[s], e.data);
    end
    @(negedge clk);
    mov[s] = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_moc_drop"}, {31'h0, moc[s]}, 32'd0);
    check_eq({tag, "_err_drop"}, {31'h0, aerr[s]}, 32'd0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      clr[s] = 1'b0; mov[s] = 1'b0; rw[s] = 1'b0; ty[s] = 2'b00;
      addr[s] = '0; din[s] = '0; last_rd[s] = '0;
    end
    for (int i = 0; i < 512; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check_eq("rst_moc", {31'h0, moc[s]}, 32'd0);
      check_eq("rst_err", {31'h0, aerr[s]}, 32'd0);
      check_eq("rst_dout", dout[s], 32'd0);
    end
    @(negedge clk);
    clr[0] = 1'b1; clr[1] = 1'b1;

    // Word write/read round trip
    mem_op(0, 1'b0, 2'b10, 9'h004, 32'hAABBCCDD, 0, "t1_wr");
    mem_op(0, 1'b1, 2'b10, 9'h004, 32'h0, 0, "t1_rd");
    check_eq("t1_const", dout[0], 32'hAABBCCDD);

    // Byte overwrite inside a word
    mem_op(0, 1'b0, 2'b00, 9'h006, 32'hFFFFFF11, 0, "t2_wrb");
    mem_op(0, 1'b1, 2'b10, 9'h004, 32'h0, 0, "t2_rdw");
    check_eq("t2_const", dout[0], 32'hAABB11DD);
    mem_op(0, 1'b1, 2'b00, 9'h005, 32'h0, 0, "t2_rdb");
    check_eq("t2_byte_const", dout[0], 32'h000000BB);

    // Misaligned halfword read and misaligned word write
    mem_op(0, 1'b1, 2'b01, 9'h005, 32'h0, 0, "t3_mis_rd");
    mem_op(0, 1'b0, 2'b10, 9'h006, 32'h01020304, 0, "t3_mis_wr");
    mem_op(0, 1'b1, 2'b10, 9'h004, 32'h0, 0, "t3_rdw");
    mem_op(0, 1'b0, 2'b01, 9'h008, 32'h0000BEEF, 0, "t3_wrh");
    mem_op(0, 1'b1, 2'b01, 9'h008, 32'h0, 0, "t3_rdh");
    mem_op(0, 1'b1, 2'b11, 9'h1FC, 32'h0, 0, "t3_rd_top");

    // Reset in WAIT aborts the write
    mem_op(0, 1'b0, 2'b10, 9'h010, 32'hCAFEF00D, 0, "t4_pre");
    @(negedge clk);
    rw[0] = 1'b0; ty[0] = 2'b10; addr[0] = 9'h010; din[0] = 32'h12345678; mov[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr[0] = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t4_rst_moc", {31'h0, moc[0]}, 32'd0);
    check_eq("t4_rst_dout", dout[0], 32'd0);
    last_rd[0] = '0;
    @(negedge clk);
    clr[0] = 1'b1; mov[0] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("t4_idle_moc", {31'h0, moc[0]}, 32'd0);
    end
    mem_op(0, 1'b1, 2'b10, 9'h010, 32'h0, 0, "t4_rd");

    // MOV withdrawn during WAIT
    @(negedge clk);
    rw[0] = 1'b0; ty[0] = 2'b10; addr[0] = 9'h010; din[0] = 32'h0BADBEEF; mov[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mov[0] = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check_eq("abort_moc", {31'h0, moc[0]}, 32'd0);
    end
    mem_op(0, 1'b1, 2'b10, 9'h010, 32'h0, 0, "abort_rd");

    // MOV held after MOC
    mem_op(0, 1'b1, 2'b10, 9'h004, 32'h0, 3, "t5_hold_rd");
    mem_op(0, 1'b0, 2'b10, 9'h020, 32'h55667788, 3, "t5_hold_wr");
    mem_op(0, 1'b1, 2'b10, 9'h020, 32'h0, 0, "t5_rd");

    // Zero-wait instance, back to back
    mem_op(1, 1'b0, 2'b10, 9'h040, 32'hDEADBEEF, 0, "t6_wr");
    mem_op(1, 1'b1, 2'b10, 9'h040, 32'h0, 0, "t6_rdw");
    mem_op(1, 1'b0, 2'b01, 9'h042, 32'h00001234, 0, "t6_wrh");
    mem_op(1, 1'b1, 2'b10, 9'h040, 32'h0, 0, "t6_rdw2");
    check_eq("t6_const", dout[1], 32'hDEAD1234);
    mem_op(1, 1'b1, 2'b01, 9'h041, 32'h0, 0, "t6_mis");
    for (int i = 0; i < 6; i++) begin
      mem_op(1, 1'(i % 2), 2'(($urandom_range(0, 2))), 9'h080 + 9'(4 * (i / 2)),
             $urandom, 0, "t6_rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
